// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-decode instruction FIFO with branch flush and in-flight response discard
// Optional IQ_BYPASS_EN: 0-cycle forward of the incoming pair when the queue is empty.
module instr_queue #(
  parameter int bits  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [bits-1:0]          in_pc,
  input  logic [bits-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bits-1:0]          out_pc,
  output logic [bits-1:0]          out_instr,
  input  logic                     flush,
  input  logic [1:0]               flush_inflight,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic {PASS, DROP} drop_state_e;

  drop_state_e       state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [1:0]        drop_cnt_q, drop_cnt_d;
  logic [2*bits-1:0] mem_q [DEPTH];
  logic              push, pop, discard, bypass;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign in_ready = !full;
  assign count    = count_q;

`ifdef IQ_BYPASS_EN
  assign bypass = empty && in_valid && out_ready && (state_q == PASS) && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair is consumed by decode directly and never touches storage.
  assign push    = in_valid && in_ready && !flush && (state_q == PASS) && !bypass;
  assign discard = in_valid && in_ready && !flush && (state_q == DROP);
  assign pop     = !empty && out_ready && !flush;

  always_comb begin
    out_valid = !empty;
    {out_pc, out_instr} = empty ? '0 : mem_q[rd_ptr_q];
    if (bypass) begin
      out_valid = 1'b1;
      {out_pc, out_instr} = {in_pc, in_instr};
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      // A new flush replaces any outstanding drop count rather than adding to it.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = flush_inflight;
      state_d    = (flush_inflight != 2'd0) ? DROP : PASS;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      case (state_q)
        DROP: begin
          if (discard) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
            if (drop_cnt_q == 2'd1) state_d = PASS;
          end
        end
        default: state_d = PASS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PASS;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

endmodule
